switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Conditions one raw, asynchronous board-switch/button input into a clean, glitch-free logic level for the basic gate cells (inverter, AND, OR, ...) downstream. The block synchronises the input into the clock domain and accepts a new level only after it has been stable for a programmable number of cycles. It also emits single-cycle rise/fall strobes. It sits between the board pins and the combinational gate layer.

## Interface
- `STABLE_CYCLES`, default 16: consecutive stable synchronised samples required before `y` changes; legal range ≥ 2.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchroniser; legal range ≥ 2.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous reset, active low. Clock is `clk`; reset is asynchronous and active-low.
- `a`  input  1  raw asynchronous switch level; may bounce.
- `y`  output  1  debounced level, registered.
- `rise`  output  1  one-cycle pulse on the edge where `y` goes 0→1.
- `fall`  output  1  one-cycle pulse on the edge where `y` goes 1→0.

## Operation
- Synchroniser: `a` passes through a chain of `SYNC_STAGES` flops. The last stage is `a_sync`. All stages reset to 0.
- FSM states (`state_t`): `S_LOW`, `S_WAIT_HIGH`, `S_HIGH`, `S_WAIT_LOW`. Reset state is `S_LOW`.
- `S_LOW`:
  - If `a_sync`=1, go to `S_WAIT_HIGH` with `cnt`=0.
  - Otherwise stay.
- `S_WAIT_HIGH`:
  - If `a_sync`=0, return to `S_LOW` and clear `cnt`. Bounce is rejected and no strobe is emitted.
  - Else if `cnt`=`STABLE_CYCLES`-1, go to `S_HIGH`, set `y`=1, pulse `rise`.
  - Else increment `cnt`.
- `S_HIGH` and `S_WAIT_LOW` mirror the above with polarities swapped. The exit from `S_WAIT_LOW` sets `y`=0 and pulses `fall`.
- `y` is 0 in `S_LOW`/`S_WAIT_HIGH` and 1 in `S_HIGH`/`S_WAIT_LOW`. `y` changes only on the FSM exit edges.
- Counter:
  - Width is `$clog2(STABLE_CYCLES)`, unsigned.
  - Never wraps: it is compared against `STABLE_CYCLES`-1 before incrementing.
  - Cleared on every entry to a WAIT state.
- `rise` and `fall` are registered, asserted for exactly one cycle, and never asserted together.
- Reset mid-wait: the pending transition is abandoned. Outputs return to their reset values immediately, asynchronously.
- Elaboration-time assertion fails if `STABLE_CYCLES` < 2 or `SYNC_STAGES` < 2.

## Timing
- Reset values: `y`=0, `rise`=0, `fall`=0, `cnt`=0, all sync flops 0, state `S_LOW`.
- Latency: let edge E0 be the first edge that samples a new stable `a`. `y` toggles, and the strobe fires, at edge E0+`SYNC_STAGES`+`STABLE_CYCLES`.
- Rejection: any pulse whose synchronised width is ≤ `STABLE_CYCLES` cycles produces no change on `y`, `rise` or `fall`.
- Back-to-back changes: after a toggle, the reverse transition needs the full latency again. The minimum spacing between strobes is `STABLE_CYCLES`+1 cycles.
- `a` held high through reset release: `y` rises and `rise` pulses `SYNC_STAGES`+`STABLE_CYCLES` edges after the first post-release edge.

## Structure
- Package `debounce_pkg`:
  - `typedef enum logic [1:0] state_t` holding the four states.
  - Default parameter constants `DEF_STABLE_CYCLES`=16 and `DEF_SYNC_STAGES`=2.
- Sub-module `sync_chain`:
  - Parameterised depth, async active-low reset.
  - Single-bit input, single-bit output.
  - Instantiated once for `a`.
- Top level holds the FSM, counter and output registers.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `SYNC_STAGES`=2.
- Reset, `a`=0 for 20 cycles → `y`=0, `rise`=`fall`=0 throughout.
- `a` 0→1 sampled at edge E0, held → `y`=1 and `rise`=1 at edge E0+6. `rise` is 0 at E0+7, and `y` stays 1.
- Bounce: `a` high for 3 cycles, low 2, high 1, low thereafter → `y` stays 0 and no strobes occur.
- Release after press (`y`=1): `a` 1→0 at E0, held → `y`=0 and `fall`=1 at E0+6, pulse width one cycle.
- Reset mid-wait: `a`=1 for 4 cycles, then assert `rst_n`=0 for 2 cycles, then release with `a` still 1 → `y`=0 during reset and `rise` at the 6th edge after release.
- Strobe mutual exclusion: random `a` activity over 10k cycles → `rise`&`fall` never both 1. Every `rise` coincides with `y` going 0→1 and every `fall` with `y` going 1→0. Checked by assertion.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared types and default parameters for the switch debouncer.
// The FSM state encoding lives here so other blocks can decode it if needed.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_t;

   localparam int DEF_STABLE_CYCLES = 16;
   localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/switch_debouncer_sync_chain.sv
// Multi-flop synchroniser for one asynchronous bit; all stages reset to 0.
module sync_chain #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[DEPTH-2:0], i_d};
   end

   assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw switch input: synchronise, then accept a new level only
// after STABLE_CYCLES consecutive agreeing samples; emits rise/fall strobes.
module switch_debouncer
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   output logic y,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   if (STABLE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_param_err
      $fatal(1, "switch_debouncer: STABLE_CYCLES and SYNC_STAGES must be >= 2");
   end

   logic             w_a_sync;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_y;
   logic             r_rise;
   logic             r_fall;

   sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_a (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (a),
      .o_q   (w_a_sync)
   );

   // Counter is compared before incrementing, so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_LOW;
         r_cnt   <= '0;
         r_y     <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            S_LOW: begin
               if (w_a_sync) begin
                  r_state <= S_WAIT_HIGH;
                  r_cnt   <= '0;
               end
            end
            S_WAIT_HIGH: begin
               if (!w_a_sync) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_HIGH;
                  r_cnt   <= '0;
                  r_y     <= 1'b1;
                  r_rise  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_HIGH: begin
               if (!w_a_sync) begin
                  r_state <= S_WAIT_LOW;
                  r_cnt   <= '0;
               end
            end
            S_WAIT_LOW: begin
               if (w_a_sync) begin
                  r_state <= S_HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
                  r_y     <= 1'b0;
                  r_fall  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_LOW;
               r_cnt   <= '0;
               r_y     <= 1'b0;
            end
         endcase
      end
   end

   assign y    = r_y;
   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised self-checking bench for switch_debouncer against a sliding-window
// reference: y flips once the last STABLE+1 synchronised samples all disagree with it.
module tb_switch_debouncer;

   localparam int SC = 4;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic a;
   logic y, rise, fall;

   int n_cmp = 0;
   int n_err = 0;

   switch_debouncer #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .y     (y),
      .rise  (rise),
      .fall  (fall)
   );

   always #5 clk = ~clk;

   // Reference model: raw samples delayed SS edges, then a window of the most
   // recent SC+1 synchronised values decides whether y flips on this edge.
   logic m_y, m_rise, m_fall;
   logic m_pipe [SS];
   logic m_win [$];
   bit   m_run;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_y = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
         for (int i = 0; i < SS; i++) m_pipe[i] = 1'b0;
         m_win.delete();
         for (int k = 0; k < SC + 1; k++) m_win.push_back(1'b0);
      end else begin
         m_run = 1'b1;
         foreach (m_win[k]) if (m_win[k] == m_y) m_run = 1'b0;
         m_rise = 1'b0; m_fall = 1'b0;
         if (m_run) begin
            m_y    = !m_y;
            m_rise = m_y;
            m_fall = !m_y;
         end
         for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = a;
         m_win.push_back(m_pipe[SS-1]);
         void'(m_win.pop_front());
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      a     = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({y, rise, fall} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_hold: {y,rise,fall}=%b expected 000", {y, rise, fall});
      end
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk) a = 1'b0;
         @(posedge clk); #1;
         n_cmp++;
         if ({y, rise, fall} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle cyc%0d: {y,rise,fall}=%b expected 000", n, {y, rise, fall});
         end
      end
   endtask

   task automatic test_press();
      logic [2:0] exp;
      @(negedge clk) a = 1'b1;
      // n counts edges from E0, the first edge that samples the new level
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         exp = {n >= SS + SC, n == SS + SC, 1'b0};
         n_cmp++;
         if ({y, rise, fall} !== exp) begin
            n_err++;
            $display("FAIL press E0+%0d: {y,rise,fall}=%b expected %b", n, {y, rise, fall}, exp);
         end
         n_cmp++;
         if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
            n_err++;
            $display("FAIL press_model E0+%0d: got %b model %b", n, {y, rise, fall}, {m_y, m_rise, m_fall});
         end
      end
   endtask

   task automatic test_release();
      logic [2:0] exp;
      @(negedge clk) a = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         exp = {n < SS + SC, 1'b0, n == SS + SC};
         n_cmp++;
         if ({y, rise, fall} !== exp) begin
            n_err++;
            $display("FAIL release E0+%0d: {y,rise,fall}=%b expected %b", n, {y, rise, fall}, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic pat [20];
      for (int i = 0; i < 20; i++) pat[i] = (i < 3) || (i == 5);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk) a = pat[n];
         @(posedge clk); #1;
         n_cmp++;
         if ({y, rise, fall} !== 3'b000) begin
            n_err++;
            $display("FAIL bounce cyc%0d: {y,rise,fall}=%b expected 000", n, {y, rise, fall});
         end
         n_cmp++;
         if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
            n_err++;
            $display("FAIL bounce_model cyc%0d: got %b model %b", n, {y, rise, fall}, {m_y, m_rise, m_fall});
         end
      end
   endtask

   task automatic test_reset_midwait();
      logic [2:0] exp;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk) a = 1'b1;
      end
      @(negedge clk) rst_n = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({y, rise, fall} !== 3'b000) begin
            n_err++;
            $display("FAIL midwait_in_reset cyc%0d: {y,rise,fall}=%b expected 000", n, {y, rise, fall});
         end
      end
      @(negedge clk) rst_n = 1'b1;
      // n=1 is the first post-release edge (E0); rise lands SS+SC edges later
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         exp = {n >= SS + SC + 1, n == SS + SC + 1, 1'b0};
         n_cmp++;
         if ({y, rise, fall} !== exp) begin
            n_err++;
            $display("FAIL midwait_release edge%0d: {y,rise,fall}=%b expected %b", n, {y, rise, fall}, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      // y is high here; reset must clear it without waiting for a clock edge
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({y, rise, fall} !== 3'b000) begin
         n_err++;
         $display("FAIL async_reset: {y,rise,fall}=%b expected 000", {y, rise, fall});
      end
      a = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic lvl;
      int   run;
      logic y_prev;
      int   n_rise = 0;
      y_prev = y;
      run    = 0;
      lvl    = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         if (run == 0) begin
            lvl = $urandom_range(0, 1);
            run = $urandom_range(1, 8);
         end
         run--;
         @(negedge clk) a = lvl;
         @(posedge clk); #1;
         n_cmp++;
         if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
            n_err++;
            $display("FAIL random_model cyc%0d: got %b model %b", n, {y, rise, fall}, {m_y, m_rise, m_fall});
         end
         n_cmp++;
         if (rise && fall) begin
            n_err++;
            $display("FAIL strobe_excl cyc%0d: rise=%b fall=%b expected not both", n, rise, fall);
         end
         n_cmp++;
         if ({rise, fall} !== {!y_prev && y, y_prev && !y}) begin
            n_err++;
            $display("FAIL strobe_edge cyc%0d: {rise,fall}=%b expected %b (y %b->%b)",
                     n, {rise, fall}, {!y_prev && y, y_prev && !y}, y_prev, y);
         end
         if (rise) n_rise++;
         y_prev = y;
      end
      n_cmp++;
      if (n_rise == 0) begin
         n_err++;
         $display("FAIL random_activity: rises=%0d expected >0", n_rise);
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_release();
      test_bounce();
      test_reset_midwait();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
